// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs instruction fields into 32-bit words behind a
// one-deep registered output stage and tags each word with an incrementing byte address.
module instr_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [2:0]        in_func3,
  input  logic [6:0]        in_func7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [15:0]       out_count,
  output logic              err_illegal,
  output logic              err_range
);

  localparam logic [2:0] CLS_LOAD   = 3'd0;
  localparam logic [2:0] CLS_ALUI   = 3'd1;
  localparam logic [2:0] CLS_STORE  = 3'd2;
  localparam logic [2:0] CLS_R      = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;
  localparam logic [2:0] CLS_JAL    = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [15:0]       count_q, count_d;
  logic              err_illegal_q, err_illegal_d;
  logic              err_range_q, err_range_d;

  logic [31:0] instr_c;
  logic        legal_c;
  logic        range_ok_c;
  logic        imm12_ok_c;
  logic        imm13_ok_c;
  logic        imm21_ok_c;
  logic        accept_c;
  logic        emit_c;

  // An immediate fits when every bit above the field's sign bit equals the sign bit.
  assign imm12_ok_c = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign imm13_ok_c = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
  assign imm21_ok_c = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];

  always_comb begin
    instr_c    = '0;
    legal_c    = 1'b1;
    range_ok_c = 1'b1;
    case (in_class)
      CLS_LOAD: begin
        instr_c    = {in_imm[11:0], in_rs1, in_func3, in_rd, OP_LOAD};
        range_ok_c = imm12_ok_c;
      end
      CLS_ALUI: begin
        instr_c    = {in_imm[11:0], in_rs1, in_func3, in_rd, OP_ALUI};
        range_ok_c = imm12_ok_c;
      end
      CLS_STORE: begin
        instr_c    = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], OP_STORE};
        range_ok_c = imm12_ok_c;
      end
      CLS_R: begin
        instr_c = {in_func7, in_rs2, in_rs1, in_func3, in_rd, OP_R};
      end
      CLS_BRANCH: begin
        instr_c    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                      in_imm[4:1], in_imm[11], OP_BRANCH};
        range_ok_c = imm13_ok_c;
      end
      CLS_JAL: begin
        instr_c    = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
        range_ok_c = imm21_ok_c;
      end
      default: legal_c = 1'b0;
    endcase
  end

  assign in_ready = ~clear & (~out_valid_q | out_ready);
  assign accept_c = in_valid & in_ready;
  assign emit_c   = accept_c & legal_c & range_ok_c;

  // Output stage, address/count bookkeeping and sticky errors; clear overrides all.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_addr_d    = out_addr_q;
    next_addr_d   = next_addr_q;
    count_d       = count_q;
    err_illegal_d = err_illegal_q;
    err_range_d   = err_range_q;
    if (clear) begin
      out_valid_d   = 1'b0;
      next_addr_d   = BASE_ADDR;
      count_d       = '0;
      err_illegal_d = 1'b0;
      err_range_d   = 1'b0;
    end else begin
      if (emit_c) begin
        out_valid_d = 1'b1;
        out_instr_d = instr_c;
        out_addr_d  = next_addr_q;
        next_addr_d = next_addr_q + ADDR_W'(4);
        count_d     = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
      end else if (out_valid_q & out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept_c & ~legal_c) err_illegal_d = 1'b1;
      if (accept_c & legal_c & ~range_ok_c) err_range_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_addr_q    <= BASE_ADDR;
      next_addr_q   <= BASE_ADDR;
      count_q       <= '0;
      err_illegal_q <= 1'b0;
      err_range_q   <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_addr_q    <= out_addr_d;
      next_addr_q   <= next_addr_d;
      count_q       <= count_d;
      err_illegal_q <= err_illegal_d;
      err_range_q   <= err_range_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_addr    = out_addr_q;
  assign out_count   = count_q;
  assign err_illegal = err_illegal_q;
  assign err_range   = err_range_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, handshake, range/illegal drops,
// address wrap on a narrow instance, clear and async reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_class = '0;
  logic [2:0]  in_func3 = '0;
  logic [6:0]  in_func7 = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [15:0] out_count;
  logic        err_illegal;
  logic        err_range;

  logic        w_in_ready, w_out_valid, w_err_illegal, w_err_range;
  logic [31:0] w_out_instr;
  logic [3:0]  w_out_addr;
  logic [15:0] w_out_count;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_func3(in_func3), .in_func7(in_func7), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .out_count(out_count), .err_illegal(err_illegal), .err_range(err_range)
  );

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'hC)) dut_w (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_class(in_class), .in_func3(in_func3), .in_func7(in_func7), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_instr(w_out_instr), .out_addr(w_out_addr),
    .out_count(w_out_count), .err_illegal(w_err_illegal), .err_range(w_err_range)
  );

  // Present one request at a negedge; returns at the negedge after it is accepted.
  task automatic issue(input logic [2:0] cls, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    int waits;
    in_class = cls; in_func3 = f3; in_func7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    #1;
    waits = 0;
    while (!in_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      chk_cnt++;
      $display("FAIL issue_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waits);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_instr !== 32'h0) $display("FAIL rst_instr: got %h want 0", out_instr); else pass_cnt++;
    chk_cnt++; if (out_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", out_addr); else pass_cnt++;
    chk_cnt++; if (out_count !== 16'h0) $display("FAIL rst_count: got %0d want 0", out_count); else pass_cnt++;
    chk_cnt++; if ({err_illegal, err_range} !== 2'b00) $display("FAIL rst_err: got %b want 00", {err_illegal, err_range}); else pass_cnt++;
    chk_cnt++; if (w_out_addr !== 4'hC) $display("FAIL rst_w_addr: got %h want c", w_out_addr); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_r_add();
    out_ready = 1'b1;
    issue(3'd3, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL add_valid: got %0b want 1", out_valid); else pass_cnt++;
    chk_cnt++; if (out_instr !== 32'h002081B3) $display("FAIL add_instr: got %h want 002081b3", out_instr); else pass_cnt++;
    chk_cnt++; if (out_addr !== 32'h0) $display("FAIL add_addr: got %h want 0", out_addr); else pass_cnt++;
    chk_cnt++; if (out_count !== 16'd1) $display("FAIL add_count: got %0d want 1", out_count); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL add_drain: got %0b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_clear();
    issue(3'd0, 3'd2, 7'd0, 5'd5, 5'd2, 5'd0, 32'd8);
    chk_cnt++; if (out_valid !== 1'b1 || out_instr !== 32'h00812283 || out_addr !== 32'h0)
      $display("FAIL b2b_load: got v=%0b %h @%h want v=1 00812283 @0", out_valid, out_instr, out_addr); else pass_cnt++;
    issue(3'd2, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 32'd12);
    chk_cnt++; if (out_valid !== 1'b1 || out_instr !== 32'h00512623 || out_addr !== 32'h4)
      $display("FAIL b2b_store: got v=%0b %h @%h want v=1 00512623 @4", out_valid, out_instr, out_addr); else pass_cnt++;
    chk_cnt++; if (out_count !== 16'd2) $display("FAIL b2b_count: got %0d want 2", out_count); else pass_cnt++;
  endtask

  task automatic test_stall();
    do_clear();
    issue(3'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
    out_ready = 1'b0;
    chk_cnt++; if (out_valid !== 1'b1 || out_instr !== 32'hFE208EE3 || out_addr !== 32'h0)
      $display("FAIL br_word: got v=%0b %h @%h want v=1 fe208ee3 @0", out_valid, out_instr, out_addr); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (out_valid !== 1'b1 || out_instr !== 32'hFE208EE3 || out_addr !== 32'h0 || in_ready !== 1'b0)
        $display("FAIL stall_hold%0d: got v=%0b %h @%h rdy=%0b want v=1 fe208ee3 @0 rdy=0",
                 i, out_valid, out_instr, out_addr, in_ready);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk_cnt++; if (out_valid !== 1'b0 || out_count !== 16'd1)
      $display("FAIL stall_release: got v=%0b cnt=%0d want v=0 cnt=1", out_valid, out_count); else pass_cnt++;
  endtask

  typedef struct packed {
    logic [2:0]  cls;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        emit;
    logic [31:0] instr;
  } vec_t;

  task automatic test_errors();
    vec_t v[10];
    logic [31:0] exp_addr;
    int exp_cnt;
    do_clear();
    issue(3'd5, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3);
    chk_cnt++; if (out_valid !== 1'b0 || err_range !== 1'b1 || err_illegal !== 1'b0)
      $display("FAIL jal_odd: got v=%0b er=%0b ei=%0b want 0 1 0", out_valid, err_range, err_illegal); else pass_cnt++;
    issue(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096);
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL alui_4096: got v=%0b want 0", out_valid); else pass_cnt++;
    issue(3'd7, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    chk_cnt++; if (out_valid !== 1'b0 || err_illegal !== 1'b1 || out_count !== 16'd0 || out_addr !== 32'h0)
      $display("FAIL class7: got v=%0b ei=%0b cnt=%0d @%h want 0 1 0 @0", out_valid, err_illegal, out_count, out_addr); else pass_cnt++;
    v[0] = '{3'd1, 5'd1, 32'hFFFFFFFF, 1'b1, 32'hFFF00093};
    v[1] = '{3'd1, 5'd0, 32'd2047,     1'b1, 32'h7FF00013};
    v[2] = '{3'd1, 5'd0, 32'hFFFFF7FF, 1'b0, 32'h0};
    v[3] = '{3'd2, 5'd0, 32'hFFFFF800, 1'b1, 32'h80000023};
    v[4] = '{3'd4, 5'd0, 32'd4094,     1'b1, 32'h7E000FE3};
    v[5] = '{3'd4, 5'd0, 32'd4096,     1'b0, 32'h0};
    v[6] = '{3'd4, 5'd0, 32'hFFFFF000, 1'b1, 32'h80000063};
    v[7] = '{3'd5, 5'd1, 32'd8,        1'b1, 32'h008000EF};
    v[8] = '{3'd5, 5'd0, 32'hFFF00000, 1'b1, 32'h8000006F};
    v[9] = '{3'd5, 5'd0, 32'h00100000, 1'b0, 32'h0};
    exp_addr = 32'h0;
    exp_cnt  = 0;
    for (int i = 0; i < 10; i++) begin
      issue(v[i].cls, 3'd0, 7'd0, v[i].rd, 5'd0, 5'd0, v[i].imm);
      chk_cnt++;
      if (v[i].emit) begin
        exp_cnt++;
        if (out_valid !== 1'b1 || out_instr !== v[i].instr || out_addr !== exp_addr || out_count !== 16'(exp_cnt))
          $display("FAIL vec%0d: got v=%0b %h @%h cnt=%0d want v=1 %h @%h cnt=%0d",
                   i, out_valid, out_instr, out_addr, out_count, v[i].instr, exp_addr, exp_cnt);
        else pass_cnt++;
        exp_addr = exp_addr + 32'd4;
      end else begin
        if (out_valid !== 1'b0 || out_count !== 16'(exp_cnt))
          $display("FAIL vec%0d_drop: got v=%0b cnt=%0d want v=0 cnt=%0d", i, out_valid, out_count, exp_cnt);
        else pass_cnt++;
      end
    end
    chk_cnt++; if ({err_illegal, err_range} !== 2'b11)
      $display("FAIL err_sticky: got %b want 11", {err_illegal, err_range}); else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_clear();
    issue(3'd3, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    chk_cnt++; if (w_out_addr !== 4'hC || w_out_instr !== 32'h000000B3 || out_addr !== 32'h0)
      $display("FAIL wrap_first: got w@%h %h main@%h want w@c 000000b3 main@0", w_out_addr, w_out_instr, out_addr); else pass_cnt++;
    issue(3'd3, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    chk_cnt++; if (w_out_addr !== 4'h0 || w_out_valid !== 1'b1 || out_addr !== 32'h4)
      $display("FAIL wrap_second: got w@%h wv=%0b main@%h want w@0 wv=1 main@4", w_out_addr, w_out_valid, out_addr); else pass_cnt++;
  endtask

  task automatic test_clear_stall();
    issue(3'd6, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    issue(3'd3, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0);
    out_ready = 1'b0;
    chk_cnt++; if (out_instr !== 32'h402081B3 || out_addr !== 32'h8 || err_illegal !== 1'b1)
      $display("FAIL sub_word: got %h @%h ei=%0b want 402081b3 @8 ei=1", out_instr, out_addr, err_illegal); else pass_cnt++;
    @(negedge clk);
    clear = 1'b1;
    #1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL clear_ready: got %0b want 0", in_ready); else pass_cnt++;
    @(negedge clk);
    clear = 1'b0;
    chk_cnt++; if (out_valid !== 1'b0 || out_count !== 16'd0 || {err_illegal, err_range} !== 2'b00)
      $display("FAIL clear_state: got v=%0b cnt=%0d err=%b want 0 0 00", out_valid, out_count, {err_illegal, err_range}); else pass_cnt++;
    out_ready = 1'b1;
    issue(3'd3, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    chk_cnt++; if (out_addr !== 32'h0 || out_count !== 16'd1 || w_out_addr !== 4'hC)
      $display("FAIL clear_resume: got @%h cnt=%0d w@%h want @0 cnt=1 w@c", out_addr, out_count, w_out_addr); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    issue(3'd3, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    out_ready = 1'b0;
    chk_cnt++; if (out_valid !== 1'b1 || out_addr !== 32'h4)
      $display("FAIL pre_rst: got v=%0b @%h want v=1 @4", out_valid, out_addr); else pass_cnt++;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_cnt++; if (out_valid !== 1'b0 || out_addr !== 32'h0 || out_count !== 16'd0)
      $display("FAIL async_rst: got v=%0b @%h cnt=%0d want 0 @0 0", out_valid, out_addr, out_count); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    issue(3'd3, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    chk_cnt++; if (out_valid !== 1'b1 || out_addr !== 32'h0 || out_count !== 16'd1)
      $display("FAIL rst_resume: got v=%0b @%h cnt=%0d want 1 @0 1", out_valid, out_addr, out_count); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_r_add();
    test_back_to_back();
    test_stall();
    test_errors();
    test_wrap();
    test_clear_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Sequential RV32I instruction encoder and program streamer for the single-cycle core. It is the inverse of the main/ALU control decoder: it takes instruction fields (class, registers, func3/func7, immediate), encodes them into 32-bit words, and emits one word per accepted request with an incrementing byte address. It feeds instruction-memory preload and test benches. The interfaces are a valid/ready input and a registered valid/ready output.

Parameters:
ADDR_W, 32, width of the output byte-address counter
BASE_ADDR, 0, address loaded on reset and on clear; must be a multiple of 4

Ports:
clk  in  1  clock; all registers update on the rising edge
rst  in  1  asynchronous, active-high reset
clear  in  1  synchronous restart: reloads the address, zeroes the count, clears the error flags
in_valid  in  1  a request is present
in_ready  out  1  the request is accepted when in_valid & in_ready
in_class  in  3  0=LOAD, 1=ALU-I, 2=STORE, 3=R, 4=BRANCH, 5=JAL, 6-7 illegal
in_func3  in  3  func3 field, passed through unchanged
in_func7  in  7  func7 field, used only for R
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_imm  in  32  signed immediate, or byte offset for BRANCH/JAL
out_valid  out  1  out_instr and out_addr are valid
out_ready  in  1  the consumer takes the word when out_valid & out_ready
out_instr  out  32  encoded instruction
out_addr  out  ADDR_W  byte address of out_instr
out_count  out  16  number of words emitted since reset/clear; saturates at 0xFFFF
err_illegal  out  1  sticky: an illegal class was accepted
err_range  out  1  sticky: an immediate was out of range or misaligned

Behaviour:
- Reset (async) values:
  - out_valid=0, out_instr=0, out_count=0, err_illegal=0, err_range=0.
  - Internal next-address register = BASE_ADDR; out_addr=BASE_ADDR.
- Ready: in_ready = !clear & (!out_valid | out_ready). This is a one-deep pipeline stage with no combinational path from in_valid to out_valid.
- Latency: a word accepted in cycle N appears on out_instr/out_addr with out_valid=1 in cycle N+1.
- Stall: while out_valid & !out_ready, out_instr and out_addr hold stable.
- Output handshake: a transfer with no new accept in the same cycle sets out_valid=0. A transfer and an accept in the same cycle keep out_valid=1 and load the new word.
- Encoding:
  - LOAD: imm[11:0],rs1,f3,rd,0000011
  - ALU-I: imm[11:0],rs1,f3,rd,0010011
  - STORE: imm[11:5],rs2,rs1,f3,imm[4:0],0100011
  - R: f7,rs2,rs1,f3,rd,0110011
  - BRANCH: imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],1100011
  - JAL: imm[20],imm[10:1],imm[11],imm[19:12],rd,1101111
- Range checks on accept:
  - LOAD, ALU-I, STORE: in_imm must lie in [-2048, 2047].
  - BRANCH: in_imm must lie in [-4096, 4094] and be even.
  - JAL: in_imm must lie in [-2^20, 2^20-2] and be even.
  - R: no immediate check.
- Rejected requests:
  - A range violation is still accepted (consumed), but no word is emitted. err_range is set, and the address and count are unchanged.
  - An illegal class is accepted and dropped the same way, setting err_illegal.
- Emit bookkeeping:
  - Each emitted word takes the current next-address. The next-address then advances by 4, wrapping modulo 2^ADDR_W.
  - out_count increments when the word is loaded into the output register.
- clear:
  - Has priority over everything else.
  - Sets out_valid=0 (any pending word is discarded), next-address=BASE_ADDR, out_count=0, err_*=0.
  - in_ready is 0 during clear.
- Reset mid-stall discards the pending word. After release, output resumes from BASE_ADDR.
- The error flags never clear except by rst or clear.

Test Plan:
- R ADD (class 3, f3=0, f7=0, rd=3, rs1=1, rs2=2), out_ready=1 -> next cycle out_instr=0x002081B3, out_addr=0x0, out_count=1.
- LOAD rd=5, rs1=2, f3=2, imm=8, then STORE rs2=5, rs1=2, f3=2, imm=12 back-to-back -> 0x00812283 @0x0, then 0x00512623 @0x4; no bubble between them.
- BRANCH rs1=1, rs2=2, f3=0, imm=-4 -> 0xFE208EE3. Then out_ready held low 5 cycles -> out_instr, out_addr and out_valid stable, in_ready=0 throughout.
- JAL imm=3, then ALU-I imm=4096, then class 7 -> err_range=1, err_illegal=1, no out_valid pulse, out_addr/out_count unchanged. A following valid word is still emitted at the next address.
- ADDR_W=4, BASE_ADDR=0xC, two R words -> out_addr 0xC then 0x0 (wrap).
- Assert clear with a word pending under stall -> out_valid=0, errors=0, and the next word is emitted at BASE_ADDR with out_count=1. Async rst mid-stream gives the same result.
